// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline encodings: next-PC ops, forwarding selects, hazard FSM states.
package pipe_defs;

  localparam logic [2:0] NPC_PC4    = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JAL    = 3'd2;
  localparam logic [2:0] NPC_JALR   = 3'd3;

  localparam logic [1:0] WD_SEL_ALU  = 2'd0;
  localparam logic [1:0] WD_SEL_DRAM = 2'd1;
  localparam logic [1:0] WD_SEL_PC4  = 2'd2;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    HZ_IDLE  = 2'd0,
    HZ_LOAD  = 2'd1,
    HZ_JWAIT = 2'd2
  } hz_state_e;

  localparam int unsigned SLOT_EX  = 0;
  localparam int unsigned SLOT_MEM = 1;
  localparam int unsigned SLOT_WB  = 2;
  localparam int unsigned SLOTS    = 3;

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Shadow of the EX/MEM/WB destination registers with forwarding priority and
// load-use detection.
module hz_scoreboard
  import pipe_defs::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_wr,
  input  logic              id_we,
  input  logic              id_is_load,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              load_hz
);

  logic [SLOTS-1:0][REG_AW-1:0] wr_q;
  logic [SLOTS-1:0]             we_q;
  logic [SLOTS-1:0]             ld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      we_q <= '0;
      ld_q <= '0;
    end else begin
      wr_q[SLOT_WB]  <= wr_q[SLOT_MEM];
      we_q[SLOT_WB]  <= we_q[SLOT_MEM];
      ld_q[SLOT_WB]  <= ld_q[SLOT_MEM];
      wr_q[SLOT_MEM] <= wr_q[SLOT_EX];
      we_q[SLOT_MEM] <= we_q[SLOT_EX];
      ld_q[SLOT_MEM] <= ld_q[SLOT_EX];
      // A stalled cycle puts a bubble into ID/EX, so the EX slot must see one too
      if (stall) begin
        wr_q[SLOT_EX] <= '0;
        we_q[SLOT_EX] <= 1'b0;
        ld_q[SLOT_EX] <= 1'b0;
      end else begin
        wr_q[SLOT_EX] <= id_wr;
        we_q[SLOT_EX] <= id_we;
        ld_q[SLOT_EX] <= id_is_load;
      end
    end
  end

  function automatic logic [1:0] pick(input logic [REG_AW-1:0] r, input logic used);
    pick = FWD_RF;
    if (used && (r != '0)) begin
      if (we_q[SLOT_WB]  && (wr_q[SLOT_WB]  == r)) pick = FWD_WB;
      if (we_q[SLOT_MEM] && (wr_q[SLOT_MEM] == r)) pick = FWD_MEM;
      if (we_q[SLOT_EX]  && (wr_q[SLOT_EX]  == r)) pick = FWD_EX;
    end
  endfunction

  always_comb begin
    fwd_a   = pick(id_rs1, id_rs1_used);
    fwd_b   = pick(id_rs2, id_rs2_used);
    load_hz = ld_q[SLOT_EX] && ((fwd_a == FWD_EX) || (fwd_b == FWD_EX));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use and control-flow stalls plus operand
// forwarding selects for ID/EX.
module hazard_ctrl
  import pipe_defs::*;
#(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned JUMP_BUBBLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ID_rs1,
  input  logic [REG_AW-1:0] ID_rs2,
  input  logic              ID_rs1_used,
  input  logic              ID_rs2_used,
  input  logic [REG_AW-1:0] ID_wR,
  input  logic              ID_we_rf,
  input  logic              ID_is_load,
  input  logic [2:0]        ID_npc_op,
  output logic              stall,
  output logic              stall_j_ID,
  output logic [1:0]        forwardA_sel,
  output logic [1:0]        forwardB_sel,
  output logic [1:0]        busy_state
);

  localparam logic [2:0] JB_CNT = 3'(JUMP_BUBBLES - 1);

  hz_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       load_hz, jmp;
  logic       stall_c, stall_j_c;

  hz_scoreboard #(.REG_AW(REG_AW)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .id_rs1      (ID_rs1),
    .id_rs2      (ID_rs2),
    .id_rs1_used (ID_rs1_used),
    .id_rs2_used (ID_rs2_used),
    .id_wr       (ID_wR),
    .id_we       (ID_we_rf),
    .id_is_load  (ID_is_load),
    .fwd_a       (forwardA_sel),
    .fwd_b       (forwardB_sel),
    .load_hz     (load_hz)
  );

  assign jmp = (ID_npc_op != NPC_PC4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HZ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // LOAD lasts one cycle and then decides exactly like IDLE, which lets a
  // jump stall start in the cycle right after a load-use bubble.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_c   = 1'b0;
    stall_j_c = 1'b0;
    unique case (state_q)
      HZ_IDLE, HZ_LOAD: begin
        if (load_hz) begin
          stall_c = 1'b1;
          state_d = HZ_LOAD;
        end else if (jmp) begin
          stall_c   = 1'b1;
          stall_j_c = 1'b1;
          cnt_d     = JB_CNT;
          state_d   = (JUMP_BUBBLES > 1) ? HZ_JWAIT : HZ_IDLE;
        end else begin
          state_d = HZ_IDLE;
        end
      end
      HZ_JWAIT: begin
        if (cnt_q == '0) begin
          state_d = HZ_IDLE;
        end else begin
          stall_c   = 1'b1;
          stall_j_c = 1'b1;
          cnt_d     = cnt_q - 3'd1;
        end
      end
      default: state_d = HZ_IDLE;
    endcase
  end

  assign stall      = stall_c & ~rst;
  assign stall_j_ID = stall_j_c & ~rst;
  assign busy_state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and random checks of hazard_ctrl against an in-flight history model.
module tb_hazard_ctrl;
  import pipe_defs::*;

  localparam int unsigned AW = 5;
  localparam int unsigned JB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ID_rs1, ID_rs2, ID_wR;
  logic          ID_rs1_used, ID_rs2_used, ID_we_rf, ID_is_load;
  logic [2:0]    ID_npc_op;
  logic          stall, stall_j_ID;
  logic [1:0]    forwardA_sel, forwardB_sel, busy_state;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(AW), .JUMP_BUBBLES(JB)) dut (
    .clk          (clk),
    .rst          (rst),
    .ID_rs1       (ID_rs1),
    .ID_rs2       (ID_rs2),
    .ID_rs1_used  (ID_rs1_used),
    .ID_rs2_used  (ID_rs2_used),
    .ID_wR        (ID_wR),
    .ID_we_rf     (ID_we_rf),
    .ID_is_load   (ID_is_load),
    .ID_npc_op    (ID_npc_op),
    .stall        (stall),
    .stall_j_ID   (stall_j_ID),
    .forwardA_sel (forwardA_sel),
    .forwardB_sel (forwardB_sel),
    .busy_state   (busy_state)
  );

  typedef struct {
    logic [AW-1:0] wr;
    logic          we;
    logic          ld;
  } ent_t;

  // hist[0] is the most recently issued instruction (now in EX), hist[2] is in WB
  ent_t hist[$];
  int   errors = 0;
  int   checks = 0;
  bit   in_jw;
  int   jleft;
  int   exp_busy;

  task automatic model_reset();
    ent_t b;
    b.wr = '0; b.we = 1'b0; b.ld = 1'b0;
    hist = {b, b, b};
    in_jw = 1'b0;
    jleft = 0;
    exp_busy = 0;
  endtask

  function automatic int fwd(input logic [AW-1:0] r, input logic used);
    if (!used || r == '0) return 0;
    for (int i = 0; i < 3; i++)
      if (hist[i].we && hist[i].wr == r) return i + 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_id(input int rs1, input bit u1, input int rs2, input bit u2,
                        input int wr, input bit we, input bit ld, input int npc);
    ID_rs1 = AW'(rs1); ID_rs1_used = u1;
    ID_rs2 = AW'(rs2); ID_rs2_used = u2;
    ID_wR = AW'(wr); ID_we_rf = we; ID_is_load = ld;
    ID_npc_op = 3'(npc);
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Checks one cycle against the model (plus optional directed constants),
  // then advances the model across the clock edge.
  task automatic cyc(input string tag, input int w_st = -1, input int w_sj = -1,
                     input int w_fa = -1, input int w_fb = -1, input int w_busy = -1);
    int  fa, fb;
    bit  lh, jmp, st, sj;
    ent_t e;
    @(negedge clk);
    fa = fwd(ID_rs1, ID_rs1_used);
    fb = fwd(ID_rs2, ID_rs2_used);
    lh = hist[0].we && hist[0].ld &&
         ((ID_rs1_used && ID_rs1 != '0 && ID_rs1 == hist[0].wr) ||
          (ID_rs2_used && ID_rs2 != '0 && ID_rs2 == hist[0].wr));
    jmp = (ID_npc_op != NPC_PC4);
    if (in_jw) begin
      st = (jleft > 0); sj = st;
    end else if (lh) begin
      st = 1'b1; sj = 1'b0;
    end else if (jmp) begin
      st = 1'b1; sj = 1'b1;
    end else begin
      st = 1'b0; sj = 1'b0;
    end
    chk({tag, ".stall"}, 8'(stall), 8'(st));
    chk({tag, ".stall_j"}, 8'(stall_j_ID), 8'(sj));
    chk({tag, ".fwdA"}, 8'(forwardA_sel), 8'(fa));
    chk({tag, ".fwdB"}, 8'(forwardB_sel), 8'(fb));
    chk({tag, ".busy"}, 8'(busy_state), 8'(exp_busy));
    if (w_st >= 0)   chk({tag, ".plan_stall"}, 8'(stall), 8'(w_st));
    if (w_sj >= 0)   chk({tag, ".plan_stall_j"}, 8'(stall_j_ID), 8'(w_sj));
    if (w_fa >= 0)   chk({tag, ".plan_fwdA"}, 8'(forwardA_sel), 8'(w_fa));
    if (w_fb >= 0)   chk({tag, ".plan_fwdB"}, 8'(forwardB_sel), 8'(w_fb));
    if (w_busy >= 0) chk({tag, ".plan_busy"}, 8'(busy_state), 8'(w_busy));
    @(posedge clk);
    if (st) begin
      e.wr = '0; e.we = 1'b0; e.ld = 1'b0;
    end else begin
      e.wr = ID_wR; e.we = ID_we_rf; e.ld = ID_is_load;
    end
    hist.push_front(e);
    void'(hist.pop_back());
    if (in_jw) begin
      if (jleft == 0) begin in_jw = 1'b0; exp_busy = 0; end
      else begin jleft--; exp_busy = 2; end
    end else if (lh) begin
      exp_busy = 1;
    end else if (jmp) begin
      if (JB > 1) begin in_jw = 1'b1; jleft = JB - 1; exp_busy = 2; end
      else exp_busy = 0;
    end else begin
      exp_busy = 0;
    end
    #1;
  endtask

  task automatic flush();
    nop(); cyc("flush"); cyc("flush"); cyc("flush");
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    set_id(1, 1, 2, 1, 3, 1, 1, 2);
    @(negedge clk);
    chk("rst.stall", 8'(stall), 8'd0);
    chk("rst.stall_j", 8'(stall_j_ID), 8'd0);
    chk("rst.fwdA", 8'(forwardA_sel), 8'd0);
    chk("rst.fwdB", 8'(forwardB_sel), 8'd0);
    chk("rst.busy", 8'(busy_state), 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    nop();
    cyc("idle", 0, 0, 0, 0, 0);

    // EX/MEM/WB forwarding distances
    set_id(0, 0, 0, 0, 5, 1, 0, 0); cyc("add_x5");
    set_id(5, 1, 7, 1, 6, 1, 0, 0); cyc("fwd_ex", 0, -1, 1);
    flush();
    set_id(0, 0, 0, 0, 5, 1, 0, 0); cyc("add_x5");
    nop(); cyc("nop");
    set_id(5, 1, 7, 1, 6, 1, 0, 0); cyc("fwd_mem", 0, -1, 2);
    flush();
    set_id(0, 0, 0, 0, 5, 1, 0, 0); cyc("add_x5");
    nop(); cyc("nop"); cyc("nop");
    set_id(5, 1, 7, 1, 6, 1, 0, 0); cyc("fwd_wb", 0, -1, 3);
    flush();

    // Load-use
    set_id(0, 0, 0, 0, 8, 1, 1, 0); cyc("lw_x8");
    set_id(8, 1, 8, 1, 9, 1, 0, 0); cyc("lu_stall", 1, 0, -1, -1, 0);
    cyc("lu_after", 0, 0, 2, 2, 1);
    flush();

    // Jump bubbles
    set_id(0, 0, 0, 0, 0, 0, 0, 2); cyc("jmp0", 1, 1, -1, -1, 0);
    cyc("jmp1", 1, 1, -1, -1, 2);
    cyc("jmp2", 0, 0, -1, -1, 2);
    nop(); cyc("jmp3", 0, 0, -1, -1, 0);
    flush();

    // Load followed by a jalr that reads the loaded register
    set_id(0, 0, 0, 0, 3, 1, 1, 0); cyc("lw_x3");
    set_id(3, 1, 0, 0, 1, 1, 0, 3); cyc("lj0", 1, 0, -1, -1, 0);
    cyc("lj1", 1, 1, 2, -1, 1);
    cyc("lj2", 1, 1, -1, -1, 2);
    cyc("lj3", 0, 0, -1, -1, 2);
    flush();

    // x0 is never forwarded
    set_id(0, 0, 0, 0, 0, 1, 1, 0); cyc("w_x0");
    set_id(0, 1, 0, 1, 4, 1, 0, 0); cyc("r_x0", 0, 0, 0, 0);
    flush();

    // Asynchronous reset while JWAIT still has one bubble left
    set_id(0, 0, 0, 0, 0, 0, 0, 2); cyc("jmp_pre_rst", 1, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.stall", 8'(stall), 8'd0);
    chk("rst_mid.stall_j", 8'(stall_j_ID), 8'd0);
    chk("rst_mid.fwdA", 8'(forwardA_sel), 8'd0);
    chk("rst_mid.fwdB", 8'(forwardB_sel), 8'd0);
    chk("rst_mid.busy", 8'(busy_state), 8'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    nop(); cyc("post_rst", 0, 0, 0, 0, 0);

    // Random traffic over a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      bit we_r;
      we_r = ($urandom_range(0, 3) != 0);
      set_id($urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), we_r,
             we_r && ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
